// File: rtl/distance_display.sv
// Distance readout: double-dabble binary-to-BCD conversion feeding a 4-digit multiplexed 7-seg display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
//
// state | meaning
// IDLE  | waiting for a load strobe
// SHIFT | 12 double-dabble add-3/shift iterations
// DONE  | publish BCD digits and over_range to the display registers
module distance_display #(
  parameter int SCAN_DIV = 50000,
  parameter int MAX_CM   = 400
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic [11:0] distance,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        over_range
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int              CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [12:0]     MAX_V     = 13'(MAX_CM);
  localparam logic [6:0]      SEG_DASH  = 7'b0111111;
  localparam logic [6:0]      SEG_OFF   = 7'b1111111;

  state_t        state, state_nxt;
  logic [3:0]    shift_cnt;
  logic [11:0]   bin_sr, dist_cap;
  logic [15:0]   bcd, bcd_adj, digits;
  logic          cap_en, shift_en, done_en;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nib, blank, an_nxt;
  logic [6:0]    seg_nxt;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 4'd11) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_en   = (state == IDLE) && load;
    shift_en = (state == SHIFT);
    done_en  = (state == DONE);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // busy is registered from SHIFT so it stays high through the DONE cycle, dropping as results land
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      shift_cnt  <= 4'd0;
      bin_sr     <= 12'd0;
      dist_cap   <= 12'd0;
      bcd        <= 16'd0;
      digits     <= 16'd0;
      over_range <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state == SHIFT);
      if (cap_en) begin
        shift_cnt <= 4'd0;
        bin_sr    <= distance;
        dist_cap  <= distance;
        bcd       <= 16'd0;
      end else if (shift_en) begin
        shift_cnt       <= shift_cnt + 4'd1;
        {bcd, bin_sr}   <= {bcd_adj[14:0], bin_sr, 1'b0};
      end
      if (done_en) begin
        digits     <= bcd;
        over_range <= ({1'b0, dist_cap} > MAX_V);
      end
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    case (digit_idx)
      2'd0:    nib = digits[3:0];
      2'd1:    nib = digits[7:4];
      2'd2:    nib = digits[11:8];
      default: nib = digits[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
    if (over_range) blank = 4'b0000;
  end
`else
  always_comb blank = 4'b0000;
`endif

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_OFF;
    if (!blank[digit_idx]) begin
      an_nxt[digit_idx] = 1'b0;
      seg_nxt           = over_range ? SEG_DASH : seg_decode(nib);
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_distance_display.sv
// Directed bench for distance_display (SCAN_DIV=4); expectations follow LEADING_ZERO_BLANK_EN if defined.
module tb_distance_display;

  logic        system_clk = 1'b0;
  logic        reset      = 1'b0;
  logic [11:0] distance   = 12'd0;
  logic        load       = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        over_range;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19, S7 = 7'h78;
  localparam logic [6:0] DASH = 7'h3F, OFF = 7'h7F;

  logic [6:0] seen_seg [4];
  logic [3:0] seen_en;
  logic       an_ok;

  distance_display #(.SCAN_DIV(4), .MAX_CM(400)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .distance   (distance),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .busy       (busy),
    .over_range (over_range)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input logic [11:0] d);
    @(negedge system_clk);
    load     = 1'b1;
    distance = d;
    @(negedge system_clk);
    load     = 1'b0;
  endtask

  // load, then verify busy window and the edge at which over_range moves
  task automatic conv(input string tag, input logic [11:0] d, input logic exp_or, input logic prev_or);
    int cnt;
    do_load(d);
    check({tag, "_busy_pre"}, busy, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge system_clk);
      if (busy) cnt++;
    end
    check({tag, "_busy_cycles"}, cnt, 12);
    check({tag, "_or_before"}, over_range, prev_or);
    @(negedge system_clk);
    check({tag, "_busy_post"}, busy, 1'b0);
    check({tag, "_or_after"}, over_range, exp_or);
  endtask

  task automatic scan_digits();
    seen_en = 4'b0000;
    an_ok   = 1'b1;
    for (int i = 0; i < 4; i++) seen_seg[i] = OFF;
    for (int c = 0; c < 20; c++) begin
      @(negedge system_clk);
      case (an)
        4'b1110: begin seen_seg[0] = seg; seen_en[0] = 1'b1; end
        4'b1101: begin seen_seg[1] = seg; seen_en[1] = 1'b1; end
        4'b1011: begin seen_seg[2] = seg; seen_en[2] = 1'b1; end
        4'b0111: begin seen_seg[3] = seg; seen_en[3] = 1'b1; end
        4'b1111: if (seg !== OFF) an_ok = 1'b0;
        default: an_ok = 1'b0;
      endcase
    end
    check("an_one_low", an_ok, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [3:0] prev_an;
    logic       found;

    // power-on reset
    repeat (3) @(negedge system_clk);
    check("rst_busy", busy, 1'b0);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, OFF);
    check("rst_or", over_range, 1'b0);
    reset = 1'b1;
    @(negedge system_clk);
    check("first_an0", an, 4'b1110);
    check("first_seg0", seg, S0);

    // reset in the middle of a conversion
    do_load(12'd123);
    repeat (5) @(negedge system_clk);
    check("mid_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, OFF);
    @(negedge system_clk);
    reset = 1'b1;
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge system_clk);
        if (busy) cnt++;
      end
      check("mid_no_resume", cnt, 0);
    end
    scan_digits();
    check("mid_ones_zero", seen_seg[0], S0);
    check("mid_or", over_range, 1'b0);

    // 237
    conv("c237", 12'd237, 1'b0, 1'b0);
    scan_digits();
    check("c237_d0", seen_seg[0], S7);
    check("c237_d1", seen_seg[1], S3);
    check("c237_d2", seen_seg[2], S2);
`ifdef LEADING_ZERO_BLANK_EN
    check("c237_en", seen_en, 4'b0111);
`else
    check("c237_en", seen_en, 4'b1111);
    check("c237_d3", seen_seg[3], S0);
`endif

    // just over and exactly at the limit
    conv("c401", 12'd401, 1'b1, 1'b0);
    scan_digits();
    check("c401_en", seen_en, 4'b1111);
    for (int i = 0; i < 4; i++) check($sformatf("c401_dash%0d", i), seen_seg[i], DASH);
    conv("c400", 12'd400, 1'b0, 1'b1);
    scan_digits();
    check("c400_d0", seen_seg[0], S0);
    check("c400_d1", seen_seg[1], S0);
    check("c400_d2", seen_seg[2], S4);
`ifdef LEADING_ZERO_BLANK_EN
    check("c400_en", seen_en, 4'b0111);
`else
    check("c400_d3", seen_seg[3], S0);
`endif

    // second load during SHIFT is dropped
    do_load(12'd237);
    repeat (3) @(negedge system_clk);
    do_load(12'd999);
    repeat (14) @(negedge system_clk);
    check("ign_busy", busy, 1'b0);
    check("ign_or", over_range, 1'b0);
    scan_digits();
    check("ign_d0", seen_seg[0], S7);
    check("ign_d1", seen_seg[1], S3);
    check("ign_d2", seen_seg[2], S2);

    // scan sequence with display 0237
    exp_an[0] = 4'b1110;
    exp_an[1] = 4'b1101;
    exp_an[2] = 4'b1011;
`ifdef LEADING_ZERO_BLANK_EN
    exp_an[3] = 4'b1111;
`else
    exp_an[3] = 4'b0111;
`endif
    found   = 1'b0;
    prev_an = an;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge system_clk);
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", found, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge system_clk);
      check($sformatf("scan_an%0d", k), an, exp_an[k/4]);
    end
    @(negedge system_clk);
    check("scan_wrap", an, 4'b1110);

    // single digit value
    conv("c7", 12'd7, 1'b0, 1'b0);
    scan_digits();
    check("c7_d0", seen_seg[0], S7);
`ifdef LEADING_ZERO_BLANK_EN
    check("c7_en", seen_en, 4'b0001);
`else
    check("c7_en", seen_en, 4'b1111);
    check("c7_d1", seen_seg[1], S0);
    check("c7_d2", seen_seg[2], S0);
    check("c7_d3", seen_seg[3], S0);
`endif

    // full scale
    conv("c4095", 12'd4095, 1'b1, 1'b0);
    scan_digits();
    check("c4095_en", seen_en, 4'b1111);
    for (int i = 0; i < 4; i++) check($sformatf("c4095_dash%0d", i), seen_seg[i], DASH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/distance_display.md
DISTANCE_DISPLAY -- requirements
Module: distance_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: system_clk cycles each digit stays enabled (2 kHz per digit at 100 MHz).
REQ-002 Parameter MAX_CM, default 400: largest distance value shown numerically.
REQ-003 system_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 distance  input  12  unsigned distance in cm, from the measurement stage's latched count.
REQ-006 load  input  1  single-cycle strobe; distance is valid in the same cycle.
REQ-007 seg  output  7  active-low segments, bit0=a … bit6=g.
REQ-008 an  output  4  active-low digit enables; an[0]=ones, an[3]=thousands.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 over_range  output  1  high while the displayed value exceeds MAX_CM.

Function
REQ-011 Conversion FSM states IDLE, SHIFT, DONE; IDLE→SHIFT on load=1 while IDLE, SHIFT→DONE after exactly 12 SHIFT cycles, DONE→IDLE unconditionally after 1 cycle.
REQ-012 On load accepted: capture distance into a 12-bit shift register and clear a 16-bit BCD accumulator.
REQ-013 Each SHIFT cycle: add 3 to every BCD nibble ≥5, then shift {BCD, binary} left one bit (double-dabble).
REQ-014 In DONE: copy the 4 BCD nibbles to the display digit register and set over_range = (captured distance > MAX_CM).
REQ-015 Latency: load at edge N → busy high from N+1 through N+12 inclusive; display register and over_range update at edge N+13.
REQ-016 load asserted while busy=1 or in DONE is ignored (not queued); display keeps the previous result.
REQ-017 Display register holds its value between conversions; a conversion never produces a partial value on seg.
REQ-018 Scan counter counts 0..SCAN_DIV-1 and wraps; at wrap, the 2-bit digit index increments, 3 wraps to 0.
REQ-019 an drives exactly one low bit, selected by digit index; seg shows the selected nibble's 0–9 pattern.
REQ-020 While over_range=1, every digit shows segment g only (dash pattern 7'b0111111).
REQ-021 Nibble values 10–15 (unreachable) decode to all segments off.
REQ-022 Scanning continues independent of conversion; seg/an are registered (one-cycle delay from digit index).
REQ-023 distance = 4095 converts to 4,0,9,5 and sets over_range with default MAX_CM.

Reset
REQ-024 reset low forces immediately: FSM=IDLE, busy=0, over_range=0, digits=0, scan counter=0, digit index=0, an=4'b1111, seg=7'b1111111.
REQ-025 reset asserted mid-conversion discards the conversion; after release the block waits for a fresh load.
REQ-026 First scan digit after reset release enables an[0] at the first rising edge.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: leading zero digits (thousands, hundreds, tens, left of first non-zero) are blanked (an bit stays high); ones digit always shown.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: all four digits always shown, including leading zeros.
REQ-029 Blanking never applies while over_range=1.

Verification
REQ-030 Reset low mid-SHIFT with distance=123 loaded → busy=0, an=4'b1111, seg=7'h7F at once; no update after release.
REQ-031 load with distance=237 → busy high 12 cycles, digits 0,2,3,7 at cycle 13; an[0] phase shows seg for 7, over_range=0.
REQ-032 load distance=401 → over_range=1, all four digits show 7'b0111111; then load 400 → digits 0,4,0,0, over_range=0.
REQ-033 load 237 then load 999 on cycle 5 → second load ignored; display 0237.
REQ-034 SCAN_DIV=4, display 0237: an sequence 1110,1101,1011,0111 each held 4 cycles, wraps to 1110.
REQ-035 LEADING_ZERO_BLANK_EN defined, load 7 → only an[0] ever goes low; undefined → all four digits enabled, showing 0,0,0,7.
